// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse sequencer: resets the mouse, enables streaming, then assembles
// 3-byte movement packets into X/Y deltas, buttons and overflow flags.
module ps2_mouse_ctrl #(
    parameter int TIMEOUT   = 25_000_000,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    input  logic       tx_idle,
    input  logic       tx_done_tick,
    output logic [7:0] tx_data,
    output logic       wr_ps2,
    output logic [8:0] xm,
    output logic [8:0] ym,
    output logic [2:0] btnm,
    output logic [1:0] ovf,
    output logic       m_done_tick,
    output logic       init_done,
    output logic       init_err
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        S_SEND_RST, S_WAIT_RST_TX, S_WAIT_ACK1, S_WAIT_BAT, S_WAIT_ID,
        S_SEND_EN, S_WAIT_EN_TX, S_WAIT_ACK2, S_PKT1, S_PKT2, S_PKT3,
        S_DONE, S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    b1_q, b1_d, b2_q, b2_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          wr_q, wr_d;
    logic [8:0]    xm_q, xm_d, ym_q, ym_d;
    logic [2:0]    btn_q, btn_d;
    logic [1:0]    ovf_q, ovf_d;
    logic          done_q, done_d, err_q, err_d;
    logic          expired, waiting, init_fail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_SEND_RST;
            tmo_q     <= '0;
            retry_q   <= '0;
            b1_q      <= '0;
            b2_q      <= '0;
            tx_data_q <= '0;
            wr_q      <= 1'b0;
            xm_q      <= '0;
            ym_q      <= '0;
            btn_q     <= '0;
            ovf_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            tx_data_q <= tx_data_d;
            wr_q      <= wr_d;
            xm_q      <= xm_d;
            ym_q      <= ym_d;
            btn_q     <= btn_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign expired = (tmo_q == TW'(TIMEOUT - 1));
    assign waiting = state_q inside {S_WAIT_RST_TX, S_WAIT_ACK1, S_WAIT_BAT, S_WAIT_ID,
                                     S_WAIT_EN_TX, S_WAIT_ACK2, S_PKT2, S_PKT3};

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        tx_data_d = tx_data_q;
        wr_d      = 1'b0;
        xm_d      = xm_q;
        ym_d      = ym_q;
        btn_d     = btn_q;
        ovf_d     = ovf_q;
        done_d    = done_q;
        err_d     = err_q;
        init_fail = 1'b0;

        unique case (state_q)
            S_SEND_RST: if (tx_idle) begin
                tx_data_d = 8'hFF;
                wr_d      = 1'b1;
                state_d   = S_WAIT_RST_TX;
            end
            S_WAIT_RST_TX: begin
                if (tx_done_tick) state_d = S_WAIT_ACK1;
                else if (expired) init_fail = 1'b1;
            end
            S_WAIT_ACK1: begin
                if (rx_done_tick) begin
                    if (rx_data == 8'hFA) state_d = S_WAIT_BAT;
                    else init_fail = 1'b1;
                end else if (expired) init_fail = 1'b1;
            end
            S_WAIT_BAT: begin
                if (rx_done_tick) begin
                    if (rx_data == 8'hAA) state_d = S_WAIT_ID;
                    else init_fail = 1'b1;
                end else if (expired) init_fail = 1'b1;
            end
            S_WAIT_ID: begin
                if (rx_done_tick) begin
                    if (rx_data == 8'h00) state_d = S_SEND_EN;
                    else init_fail = 1'b1;
                end else if (expired) init_fail = 1'b1;
            end
            S_SEND_EN: if (tx_idle) begin
                tx_data_d = 8'hF4;
                wr_d      = 1'b1;
                state_d   = S_WAIT_EN_TX;
            end
            S_WAIT_EN_TX: begin
                if (tx_done_tick) state_d = S_WAIT_ACK2;
                else if (expired) init_fail = 1'b1;
            end
            S_WAIT_ACK2: begin
                if (rx_done_tick) begin
                    if (rx_data == 8'hFA) begin
                        state_d = S_PKT1;
                        done_d  = 1'b1;
                    end else init_fail = 1'b1;
                end else if (expired) init_fail = 1'b1;
            end
            // Bytes without the always-one bit 3 cannot start a packet: drop to resync.
            S_PKT1: if (rx_done_tick && rx_data[3]) begin
                b1_d    = rx_data;
                state_d = S_PKT2;
            end
            S_PKT2: begin
                if (rx_done_tick) begin
                    b2_d    = rx_data;
                    state_d = S_PKT3;
                end else if (expired) state_d = S_PKT1;
            end
            // Outputs load on the edge into DONE so they are valid alongside m_done_tick.
            S_PKT3: begin
                if (rx_done_tick) begin
                    xm_d    = {b1_q[4], b2_q};
                    ym_d    = {b1_q[5], rx_data};
                    btn_d   = b1_q[2:0];
                    ovf_d   = b1_q[7:6];
                    state_d = S_DONE;
                end else if (expired) state_d = S_PKT1;
            end
            S_DONE:  state_d = S_PKT1;
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_SEND_RST;
        endcase

        if (init_fail) begin
            retry_d = retry_q + RW'(1);
            if (retry_d < RW'(MAX_RETRY)) begin
                state_d = S_SEND_RST;
            end else begin
                state_d = S_FAIL;
                err_d   = 1'b1;
                done_d  = 1'b0;
            end
        end
    end

    assign tmo_d = (state_d != state_q || !waiting) ? '0 : tmo_q + TW'(1);

    assign tx_data     = tx_data_q;
    assign wr_ps2      = wr_q;
    assign xm          = xm_q;
    assign ym          = ym_q;
    assign btnm        = btn_q;
    assign ovf         = ovf_q;
    assign m_done_tick = (state_q == S_DONE);
    assign init_done   = done_q;
    assign init_err    = err_q;
endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl: packet model with per-cycle output compare,
// plus literal checks of init, resync, timeout, overflow, reset and retry behaviour.
module tb_ps2_mouse_ctrl;
    localparam int TMO = 100;
    localparam int MR  = 3;

    logic       clk = 1'b0, reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_tick = 1'b0, tx_idle = 1'b0, tx_done_tick = 1'b0;
    logic [7:0] tx_data;
    logic       wr_ps2, m_done_tick, init_done, init_err;
    logic [8:0] xm, ym;
    logic [2:0] btnm;
    logic [1:0] ovf;

    ps2_mouse_ctrl #(.TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
        .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .tx_data(tx_data),
        .wr_ps2(wr_ps2), .xm(xm), .ym(ym), .btnm(btnm), .ovf(ovf),
        .m_done_tick(m_done_tick), .init_done(init_done), .init_err(init_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [2:0] b;
        logic [1:0] o;
    } pkt_t;

    int         checks = 0, errors = 0, wr_cnt = 0, tick_cnt = 0;
    logic [7:0] wr_log[$];
    pkt_t       exp_q[$];
    pkt_t       exp_cur = '0;
    bit         prev_tick = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet meaning from the mouse protocol: sign bits turn the 8-bit magnitudes into signed deltas.
    function automatic pkt_t model(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        pkt_t p;
        int   dx, dy;
        dx  = int'(b2) - (b1[4] ? 256 : 0);
        dy  = int'(b3) - (b1[5] ? 256 : 0);
        p.x = 9'(dx);
        p.y = 9'(dy);
        p.b = {b1[2], b1[1], b1[0]};
        p.o = {b1[7], b1[6]};
        return p;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_ps2) begin
                wr_cnt++;
                wr_log.push_back(tx_data);
            end
            if (m_done_tick) begin
                tick_cnt++;
                chk("tick_single_cycle", {31'b0, prev_tick}, 32'd0);
                if (exp_q.size() == 0) chk("unexpected_tick", 32'd1, 32'd0);
                else exp_cur = exp_q.pop_front();
            end
            prev_tick = m_done_tick;
            chk("pkt_outputs", {9'b0, xm, ym, btnm, ovf}, {9'b0, exp_cur});
        end else begin
            prev_tick = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        rx_data      = b;
        rx_done_tick = 1'b1;
        cyc(1);
        rx_done_tick = 1'b0;
        if (last) chk("tick_latency", {31'b0, m_done_tick}, 32'd1);
        cyc(2);
    endtask

    task automatic pulse_txdone();
        tx_done_tick = 1'b1;
        cyc(1);
        tx_done_tick = 1'b0;
        cyc(1);
    endtask

    task automatic wait_wr(input int target, input string name);
        int n;
        n = 0;
        while (wr_cnt < target && n < 50) begin
            cyc(1);
            n++;
        end
        chk(name, {31'b0, (wr_cnt >= target)}, 32'd1);
    endtask

    task automatic send_pkt(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back(model(b1, b2, b3));
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        send_byte(b3, 1'b1);
    endtask

    initial begin
        int t0, base;
        cyc(2);
        chk("rst_pkt", {9'b0, xm, ym, btnm, ovf}, 32'd0);
        chk("rst_ctl", {20'b0, tx_data, wr_ps2, m_done_tick, init_done, init_err}, 32'd0);
        @(negedge clk) reset = 1'b0;
        cyc(4);
        chk("no_wr_while_busy", wr_cnt, 0);

        // Clean init
        tx_idle = 1'b1;
        wait_wr(1, "wr_reset_cmd");
        pulse_txdone();
        send_byte(8'hFA, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_wr(2, "wr_enable_cmd");
        pulse_txdone();
        chk("init_done_before_ack", {31'b0, init_done}, 32'd0);
        send_byte(8'hFA, 1'b0);
        chk("init_done", {31'b0, init_done}, 32'd1);
        chk("init_err_clean", {31'b0, init_err}, 32'd0);
        chk("wr_count_init", wr_cnt, 2);
        chk("tx_byte0", {24'b0, wr_log[0]}, 32'hFF);
        chk("tx_byte1", {24'b0, wr_log[1]}, 32'hF4);

        // Basic packet, negative X
        send_pkt(8'h19, 8'hF0, 8'h05);
        chk("pkt1_xm", {23'b0, xm}, 32'h1F0);
        chk("pkt1_ym", {23'b0, ym}, 32'h005);
        chk("pkt1_btn", {29'b0, btnm}, 32'h1);
        chk("pkt1_ovf", {30'b0, ovf}, 32'h0);

        // Resync: leading byte with bit3=0 is dropped
        t0 = tick_cnt;
        send_byte(8'h02, 1'b0);
        send_pkt(8'h08, 8'h10, 8'h20);
        chk("resync_xm", {23'b0, xm}, 32'h010);
        chk("resync_ym", {23'b0, ym}, 32'h020);
        chk("resync_btn", {29'b0, btnm}, 32'h0);
        cyc(1);
        chk("resync_ticks", tick_cnt - t0, 1);

        // Inter-byte timeout drops the partial packet
        t0 = tick_cnt;
        send_byte(8'h08, 1'b0);
        send_byte(8'h7F, 1'b0);
        cyc(TMO);
        send_pkt(8'h08, 8'h01, 8'h02);
        chk("tmo_xm", {23'b0, xm}, 32'h001);
        chk("tmo_ym", {23'b0, ym}, 32'h002);
        cyc(1);
        chk("tmo_ticks", tick_cnt - t0, 1);

        // Overflow flags with both deltas negative
        send_pkt(8'hF9, 8'h80, 8'h7F);
        chk("ovf_flags", {30'b0, ovf}, 32'h3);
        chk("ovf_xm", {23'b0, xm}, 32'h180);
        chk("ovf_ym", {23'b0, ym}, 32'h17F);

        // Asynchronous reset mid-packet
        send_byte(8'h08, 1'b0);
        send_byte(8'h10, 1'b0);
        exp_q.delete();
        exp_cur = '0;
        base = wr_cnt;
        reset = 1'b1;
        #1;
        chk("midrst_pkt", {9'b0, xm, ym, btnm, ovf}, 32'd0);
        chk("midrst_ctl", {20'b0, tx_data, wr_ps2, m_done_tick, init_done, init_err}, 32'd0);
        cyc(2);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        chk("post_rst_wr", {31'b0, wr_ps2}, 32'd1);
        chk("post_rst_txdata", {24'b0, tx_data}, 32'hFF);
        cyc(1);

        // Every reset answered with FE: three attempts, then sticky failure
        for (int i = 0; i < MR; i++) begin
            wait_wr(base + i + 1, "wr_retry");
            pulse_txdone();
            send_byte(8'hFE, 1'b0);
        end
        chk("fail_err", {31'b0, init_err}, 32'd1);
        chk("fail_done", {31'b0, init_done}, 32'd0);
        chk("fail_wr_count", wr_cnt - base, MR);
        send_byte(8'hFA, 1'b0);
        pulse_txdone();
        send_byte(8'hAA, 1'b0);
        cyc(20);
        chk("fail_ignores_inputs", wr_cnt - base, MR);
        chk("fail_sticky", {31'b0, init_err}, 32'd1);
        chk("no_missing_ticks", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
